// File: rtl/seg_display_ctrl.sv
// Front-panel display controller: BUS LEDs, a multi-digit hex/decimal readout with
// sequential double-dabble conversion, and a timestep digit with a blinking DONE point.
`timescale 1ns/1ps
module seg_display_ctrl #(
   parameter int DATA_W     = 10,
   parameter int NUM_DIGITS = 4,
   parameter int TIME_W     = 2,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_W-1:0]       BUS,
   input  logic [DATA_W-1:0]       REG,
   input  logic [TIME_W-1:0]       TIME,
   input  logic                    PEEKb,
   input  logic                    DONE,
   input  logic                    DEC_MODE,
   output logic [DATA_W-1:0]       LED_B,
   output logic [7*NUM_DIGITS-1:0] DHEX,
   output logic [7:0]              THEX,
   output logic                    BUSY
);

   localparam int FIELD_W = 4*NUM_DIGITS;
   localparam int CNT_W   = $clog2(DATA_W+1);
   localparam int BLINK_W = $clog2(BLINK_DIV+1);

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
   state_t state, state_next;

   logic [DATA_W-1:0]       sel, lat_val, bin;
   logic                    lat_dec, dirty, ovf, changed, latch, seen, unlit;
   logic [FIELD_W-1:0]      field, field_adj;
   logic [CNT_W-1:0]        cnt;
   logic [7*NUM_DIGITS-1:0] disp;
   logic [BLINK_W-1:0]      blink_cnt;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   assign sel     = PEEKb ? BUS : REG;
   assign changed = (sel != lat_val) || (DEC_MODE != lat_dec);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      BUSY       = 1'b0;
      latch      = 1'b0;
      case (state)
         IDLE: begin
            if (dirty || changed) begin
               latch      = 1'b1;
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            BUSY = 1'b1;
            if (!lat_dec || cnt == CNT_W'(DATA_W-1)) state_next = UPDATE;
         end
         UPDATE: begin
            BUSY       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Add-3 correction applied to every BCD digit before each shift.
   always_comb begin
      field_adj = field;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (field[4*i +: 4] >= 4'd5) field_adj[4*i +: 4] = field[4*i +: 4] + 4'd3;
      end
   end

   // A 1 leaving the top BCD digit means the value needs more digits than exist.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dirty   <= 1'b1;
         lat_val <= '0;
         lat_dec <= 1'b0;
         bin     <= '0;
         field   <= '0;
         ovf     <= 1'b0;
         cnt     <= '0;
         LED_B   <= '0;
         DHEX    <= {NUM_DIGITS{7'h7F}};
      end else begin
         LED_B <= BUS;
         if (latch) begin
            dirty   <= 1'b0;
            lat_val <= sel;
            lat_dec <= DEC_MODE;
            bin     <= sel;
            field   <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
         end else if (state == CONVERT) begin
            if (lat_dec) begin
               field <= {field_adj[FIELD_W-2:0], bin[DATA_W-1]};
               bin   <= bin << 1;
               ovf   <= ovf | field_adj[FIELD_W-1];
               cnt   <= cnt + 1'b1;
            end else begin
               field <= FIELD_W'(lat_val);
            end
         end else if (state == UPDATE) begin
            DHEX <= disp;
         end
      end
   end

   // Leading-zero blanking scans from the top digit; digit 0 is always shown.
   always_comb begin
      seen = 1'b0;
      disp = '1;
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
         if (field[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
         if (ovf)       disp[7*i +: 7] = 7'h3F;
         else if (seen) disp[7*i +: 7] = glyph(field[4*i +: 4]);
         else           disp[7*i +: 7] = 7'h7F;
      end
   end

   // Holding the counter at zero while DONE is low makes every rising edge start lit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         THEX      <= 8'hFF;
         blink_cnt <= '0;
         unlit     <= 1'b0;
      end else begin
         THEX[6:0] <= glyph(4'(TIME));
         if (!DONE) begin
            blink_cnt <= '0;
            unlit     <= 1'b0;
            THEX[7]   <= 1'b1;
         end else begin
            THEX[7] <= unlit;
            if (blink_cnt == BLINK_W'(BLINK_DIV-1)) begin
               blink_cnt <= '0;
               unlit     <= ~unlit;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed and randomized steps checked against a
// digit-arithmetic display model; a 4-digit and a 3-digit instance run side by side.
`timescale 1ns/1ps
module tb_seg_display_ctrl;

   localparam int DATA_W    = 10;
   localparam int TIME_W    = 2;
   localparam int BLINK_DIV = 4;
   localparam int W4        = 28;
   localparam int W3        = 21;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [DATA_W-1:0] BUS = '0;
   logic [DATA_W-1:0] REG = '0;
   logic [TIME_W-1:0] TIME = '0;
   logic              PEEKb = 1'b0;
   logic              DONE = 1'b0;
   logic              DEC_MODE = 1'b0;
   logic [DATA_W-1:0] LED_B, LED_B3;
   logic [W4-1:0]     DHEX;
   logic [W3-1:0]     DHEX3;
   logic [7:0]        THEX, THEX3;
   logic              BUSY, BUSY3;

   always #5 CLK = ~CLK;

   seg_display_ctrl #(.DATA_W(DATA_W), .NUM_DIGITS(4), .TIME_W(TIME_W), .BLINK_DIV(BLINK_DIV)) u_dut (
      .CLK(CLK), .RST(RST), .BUS(BUS), .REG(REG), .TIME(TIME), .PEEKb(PEEKb), .DONE(DONE),
      .DEC_MODE(DEC_MODE), .LED_B(LED_B), .DHEX(DHEX), .THEX(THEX), .BUSY(BUSY));

   seg_display_ctrl #(.DATA_W(DATA_W), .NUM_DIGITS(3), .TIME_W(TIME_W), .BLINK_DIV(BLINK_DIV)) u_dut3 (
      .CLK(CLK), .RST(RST), .BUS(BUS), .REG(REG), .TIME(TIME), .PEEKb(PEEKb), .DONE(DONE),
      .DEC_MODE(DEC_MODE), .LED_B(LED_B3), .DHEX(DHEX3), .THEX(THEX3), .BUSY(BUSY3));

   int compared   = 0;
   int mismatched = 0;

   logic [W4-1:0] exp_q[$];
   logic [W3-1:0] exp3_q[$];
   logic [6:0]    glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [W4-1:0] shown4;
   logic [W3-1:0] shown3;
   logic [DATA_W-1:0] lat_sel;
   bit            lat_dec;
   bit            force_conv;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Display built from the value's digits with division/shift arithmetic.
   function automatic logic [W4-1:0] model_disp(input int v, input bit dec, input int nd);
      int dig[4];
      int top;
      int p;
      logic [W4-1:0] r;
      r = '1;
      p = 1;
      for (int i = 0; i < nd; i++) p = p * 10;
      if (dec && v >= p) begin
         for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'h3F;
         return r;
      end
      top = 0;
      for (int i = 0; i < nd; i++) begin
         dig[i] = dec ? (v / (10 ** i)) % 10 : (v >> (4*i)) & 15;
         if (dig[i] != 0) top = i;
      end
      for (int i = 0; i < nd; i++) r[7*i +: 7] = (i <= top) ? glyph_tab[dig[i]] : 7'h7F;
      return r;
   endfunction

   task automatic push_exp(input logic [DATA_W-1:0] v, input bit dec);
      exp_q.push_back(model_disp(int'(v), dec, 4));
      exp3_q.push_back(W3'(model_disp(int'(v), dec, 3)));
   endtask

   task automatic wait_conv(input int exp_busy, input int change_at, input logic [DATA_W-1:0] new_reg);
      int busy_n  = 0;
      int busy3_n = 0;
      bit stable  = 1'b1;
      for (int c = 0; c < 60; c++) begin
         step();
         if (BUSY3) busy3_n++;
         if (BUSY) begin
            busy_n++;
            if (DHEX !== shown4 || DHEX3 !== shown3) stable = 1'b0;
            if (change_at != 0 && busy_n == change_at) REG = new_reg;
         end else if (busy_n > 0 || c >= 3) begin
            break;
         end
      end
      check("display_stable_while_busy", 64'(stable), 64'd1);
      check("busy_cycles", 64'(busy_n), 64'(exp_busy));
      check("busy_cycles_3dig", 64'(busy3_n), 64'(exp_busy));
      shown4 = exp_q.pop_front();
      shown3 = exp3_q.pop_front();
      check("dhex", 64'(DHEX), 64'(shown4));
      check("dhex_3dig", 64'(DHEX3), 64'(shown3));
   endtask

   task automatic apply(input logic [DATA_W-1:0] reg_v, input logic [DATA_W-1:0] bus_v,
                        input bit peek, input bit dec);
      logic [DATA_W-1:0] s;
      REG = reg_v;  BUS = bus_v;  PEEKb = peek;  DEC_MODE = dec;
      s = peek ? bus_v : reg_v;
      if (force_conv || s != lat_sel || dec != lat_dec) begin
         force_conv = 1'b0;
         lat_sel    = s;
         lat_dec    = dec;
         push_exp(s, dec);
         wait_conv(dec ? DATA_W + 1 : 2, 0, '0);
      end else begin
         repeat (3) step();
         check("idle_not_busy", 64'(BUSY), 64'd0);
         check("idle_display_hold", 64'(DHEX), 64'(shown4));
      end
      check("led_b", 64'(LED_B), 64'(bus_v));
   endtask

   initial begin
      shown4     = '1;
      shown3     = '1;
      lat_sel    = '0;
      lat_dec    = 1'b0;
      force_conv = 1'b1;

      // Reset values
      REG = 10'h2A5;
      repeat (2) step();
      check("rst_led_b", 64'(LED_B), 64'd0);
      check("rst_dhex", 64'(DHEX), 64'hFFF_FFFF);
      check("rst_thex", 64'(THEX), 64'hFF);
      check("rst_busy", 64'(BUSY), 64'd0);

      // Hex values; the first conversion is forced by reset
      RST = 1'b0;
      apply(10'h2A5, '0, 1'b0, 1'b0);
      check("t1_hex_2a5", 64'(DHEX), 64'({7'h7F, 7'h24, 7'h08, 7'h12}));
      apply(10'd0, '0, 1'b0, 1'b0);
      check("t1_hex_zero", 64'(DHEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

      // Decimal values and overflow on the 3-digit instance
      apply(10'd999, '0, 1'b0, 1'b1);
      check("t2_dec_999", 64'(DHEX), 64'({7'h7F, 7'h10, 7'h10, 7'h10}));
      apply(10'd1023, '0, 1'b0, 1'b1);
      check("t2_dec_1023", 64'(DHEX), 64'({7'h79, 7'h40, 7'h24, 7'h30}));
      check("t2_ovf_3dig", 64'(DHEX3), 64'({7'h3F, 7'h3F, 7'h3F}));

      // Peek and LED path
      apply(10'd5, '0, 1'b0, 1'b0);
      check("t3_hex_5", 64'(DHEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
      BUS = 10'h3FF;
      check("t3_led_before_edge", 64'(LED_B), 64'd0);
      step();
      check("t3_led_after_edge", 64'(LED_B), 64'h3FF);
      apply(10'd5, 10'h3FF, 1'b1, 1'b0);
      check("t3_peek_3ff", 64'(DHEX), 64'({7'h7F, 7'h30, 7'h0E, 7'h0E}));

      // Input change in the middle of a decimal conversion
      PEEKb = 1'b0;  DEC_MODE = 1'b1;  REG = 10'd12;
      lat_sel = 10'd12;  lat_dec = 1'b1;
      push_exp(10'd12, 1'b1);
      wait_conv(DATA_W + 1, 3, 10'd34);
      check("t4_first_12", 64'(DHEX), 64'({7'h7F, 7'h7F, 7'h79, 7'h24}));
      lat_sel = 10'd34;
      push_exp(10'd34, 1'b1);
      wait_conv(DATA_W + 1, 0, '0);

      // Timestep glyph and DONE blink
      for (int t = 0; t < 4; t++) begin
         TIME = TIME_W'(t);
         step();
         check("t5_time_glyph", 64'(THEX[6:0]), 64'(glyph_tab[t]));
      end
      TIME = 2'd2;
      step();
      check("t5_time_2", 64'(THEX[6:0]), 64'h24);
      check("t5_dp_off", 64'(THEX[7]), 64'd1);
      DONE = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         step();
         check("t5_blink", 64'(THEX[7]), 64'(((k - 1) / BLINK_DIV) % 2));
      end
      DONE = 1'b0;
      step();
      check("t5_done_low", 64'(THEX[7]), 64'd1);
      DONE = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check("t5_blink_restart", 64'(THEX[7]), 64'(((k - 1) / BLINK_DIV) % 2));
      end
      DONE = 1'b0;
      step();

      // Reset during a decimal conversion
      REG = 10'd700;
      step();
      check("t6_busy_before_rst", 64'(BUSY), 64'd1);
      repeat (2) step();
      RST = 1'b1;
      step();
      check("t6_rst_dhex", 64'(DHEX), 64'hFFF_FFFF);
      check("t6_rst_dhex_3dig", 64'(DHEX3), 64'h1F_FFFF);
      check("t6_rst_thex", 64'(THEX), 64'hFF);
      check("t6_rst_busy", 64'(BUSY), 64'd0);
      RST = 1'b0;
      shown4 = '1;
      shown3 = '1;
      force_conv = 1'b1;
      apply(10'd700, BUS, 1'b0, 1'b1);

      // Randomized values, sources and modes
      for (int n = 0; n < 30; n++) begin
         TIME = TIME_W'($urandom_range(0, 3));
         apply(DATA_W'($urandom_range(0, 1023)), DATA_W'($urandom_range(0, 1023)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("rand_time_glyph", 64'(THEX[6:0]), 64'(glyph_tab[TIME]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
